// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for a UART transmitter. It accepts a byte plus parity
// settings, then drives the serial line through start bit, eight data bits
// (taken from an external LSB-first serializer), an optional parity bit and a
// single stop bit. A new request arriving during the stop bit chains straight
// into the next frame, so Busy never drops between back-to-back frames.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (only 8 is supported)
//
// Ports:
//   CLK         system clock, rising-edge active
//   RST         asynchronous, active-low reset
//   P_Data      byte to transmit, sampled with Data_Valid
//   Data_Valid  single-cycle transmit request (honoured in IDLE or STOP only)
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   ser_data    current data bit presented by the serializer
//   ser_done    serializer flag, high while the last data bit is presented
//   ser_en      serializer shift enable, high exactly while in DATA
//   TX_OUT      registered serial line, idles high
//   Busy        registered frame-in-progress flag
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  parEn_q, parEn_d;
    logic                  parTyp_q, parTyp_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  parityBit;

    // Requests are only honoured between frames or during the stop bit;
    // anything arriving earlier in a frame is silently dropped.
    assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

    // Even parity makes the total count of ones even; odd flips that bit.
    assign parityBit = (^data_q) ^ parTyp_q;

    assign ser_en = (state_q == DATA);
    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // Next-state decode plus the registered-output preload. TX_OUT and Busy
    // are computed from the current state and captured on the same edge, so
    // the line lags the state register by exactly one period.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parEn_d  = parEn_q;
        parTyp_d = parTyp_q;
        tx_d     = 1'b1;
        busy_d   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                tx_d    = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                tx_d = ser_data;
                if (ser_done) begin
                    state_d = parEn_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_d    = parityBit;
                state_d = STOP;
            end
            STOP: begin
                tx_d    = 1'b1;
                state_d = accept ? START : IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Capture the frame settings at acceptance so later input changes
        // cannot corrupt the frame in flight.
        if (accept) begin
            data_d   = P_Data;
            parEn_d  = PAR_EN;
            parTyp_d = PAR_TYP;
        end
    end

    // State, latched frame settings and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            parEn_q  <= 1'b0;
            parTyp_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parEn_q  <= parEn_d;
            parTyp_q <= parTyp_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Self-checking bench for uart_tx_ctrl. A small LSB-first serializer model
// feeds ser_data/ser_done, and the expected line waveform of every frame is
// built from the frame format: start 0, data LSB first, optional parity, stop 1.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_Data;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    // Serializer model: holds the byte being sent, steps one bit per enabled
    // clock and rewinds whenever the enable is low.
    logic [7:0] serCur;
    logic [7:0] serNext;
    logic [3:0] serIdx;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_Data    (P_Data),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer position tracking.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            serIdx <= 4'd0;
            serCur <= 8'd0;
        end else if (ser_en) begin
            serIdx <= serIdx + 4'd1;
        end else begin
            serIdx <= 4'd0;
            serCur <= serNext;
        end
    end

    assign ser_data = serCur[serIdx[2:0]];
    assign ser_done = ser_en && (serIdx == 4'd7);

    // Reference model: parity from a count of ones.
    function automatic logic parityOf(input logic [7:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        if (typ) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    // Reference model: bit k of the frame as seen on the line.
    function automatic logic frameBit(input logic [7:0] d, input logic en,
                                      input logic typ, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (en && k == 9) return parityOf(d, typ);
        return 1'b1;
    endfunction

    task automatic scrambleInputs();
        P_Data  = 8'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle TX_OUT got %b want 1", name, TX_OUT);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle Busy got %b want 0", name, Busy);
        end
        checks++;
        if (ser_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle ser_en got %b want 0", name, ser_en);
        end
    endtask

    // Pulse a request from IDLE and land in the period after the acceptance
    // edge, where the line is still idle.
    task automatic startRequest(input logic [7:0] d, input logic en,
                                input logic typ, input string name);
        @(negedge CLK);
        Data_Valid = 1'b1;
        P_Data     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        serNext    = d;
        @(negedge CLK);
        Data_Valid = 1'b0;
        scrambleInputs();
        checkIdle({name, "_accept"});
    endtask

    // Walk one frame period by period. Optionally inject an ignored request at
    // period injectAt, or chain a follow-on request during the last-but-one bit.
    task automatic checkFrame(input logic [7:0] d, input logic en, input logic typ,
                              input bit chain, input logic [7:0] nd,
                              input logic nen, input logic ntyp,
                              input int injectAt, input string name);
        int len = en ? 11 : 10;
        for (int k = 0; k < len; k++) begin
            logic expTx;
            @(negedge CLK);
            expTx = frameBit(d, en, typ, k);
            checks++;
            if (TX_OUT !== expTx) begin
                errors++;
                $display("[TB] FAIL %s TX_OUT bit %0d got %b want %b", name, k, TX_OUT, expTx);
            end
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s Busy bit %0d got %b want 1", name, k, Busy);
            end
            checks++;
            if (ser_en !== (k < 8)) begin
                errors++;
                $display("[TB] FAIL %s ser_en bit %0d got %b want %b", name, k, ser_en, (k < 8));
            end
            if (Data_Valid) begin
                Data_Valid = 1'b0;
                scrambleInputs();
            end
            if (k == injectAt) begin
                Data_Valid = 1'b1;
                P_Data     = 8'h3C;
                PAR_EN     = ~en;
                PAR_TYP    = ~typ;
            end
            if (chain && k == len - 2) begin
                Data_Valid = 1'b1;
                P_Data     = nd;
                PAR_EN     = nen;
                PAR_TYP    = ntyp;
                serNext    = nd;
            end
        end
        if (!chain) begin
            @(negedge CLK);
            checkIdle({name, "_after"});
        end
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_Data     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        serNext    = 8'h00;
        repeat (2) @(negedge CLK);
        checkIdle("reset_held");
        RST = 1'b1;
        @(negedge CLK);
        checkIdle("reset_released");
    endtask

    task automatic test_even_parity();
        startRequest(8'hA5, 1'b1, 1'b0, "even");
        checkFrame(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1, "even");
    endtask

    task automatic test_odd_parity();
        startRequest(8'h00, 1'b1, 1'b1, "odd");
        checkFrame(8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, -1, "odd");
    endtask

    task automatic test_no_parity();
        startRequest(8'hFF, 1'b0, 1'b0, "nopar");
        checkFrame(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1, "nopar");
    endtask

    task automatic test_ignore_midframe();
        startRequest(8'h81, 1'b1, 1'b1, "ignore");
        checkFrame(8'h81, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4, "ignore");
        repeat (3) begin
            @(negedge CLK);
            checkIdle("ignore_nosecond");
        end
    endtask

    task automatic test_back_to_back();
        startRequest(8'hC3, 1'b1, 1'b0, "b2b");
        checkFrame(8'hC3, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, -1, "b2b_first");
        checkFrame(8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1, "b2b_second");
    endtask

    task automatic test_reset_midframe();
        startRequest(8'h96, 1'b1, 1'b0, "rstmid");
        for (int k = 0; k <= 4; k++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== frameBit(8'h96, 1'b1, 1'b0, k)) begin
                errors++;
                $display("[TB] FAIL rstmid TX_OUT bit %0d got %b want %b", k, TX_OUT,
                         frameBit(8'h96, 1'b1, 1'b0, k));
            end
        end
        RST = 1'b0;
        #1;
        checkIdle("rstmid_async");
        @(negedge CLK);
        RST = 1'b1;
        startRequest(8'h3C, 1'b1, 1'b1, "rstmid_next");
        checkFrame(8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, -1, "rstmid_next");
    endtask

    task automatic test_random();
        logic [7:0] d, nd;
        logic       en, typ, nen, ntyp;
        bit         chain;
        d   = 8'($urandom);
        en  = 1'($urandom);
        typ = 1'($urandom);
        startRequest(d, en, typ, "rand");
        for (int i = 0; i < 10; i++) begin
            chain = (i < 9) && ($urandom_range(0, 1) == 1);
            nd    = 8'($urandom);
            nen   = 1'($urandom);
            ntyp  = 1'($urandom);
            checkFrame(d, en, typ, chain, nd, nen, ntyp, -1, "rand");
            d   = nd;
            en  = nen;
            typ = ntyp;
            if (!chain && i < 9) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge CLK);
                    checkIdle("rand_gap");
                end
                startRequest(d, en, typ, "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
